ace_master_port: RTL and testbench

ACE_MASTER_PORT -- requirements
Module: ace_master_port

---
 rtl/ace_master_port_pkg.sv | 31 +++
 rtl/ace_master_port_if.sv | 59 +++++
 rtl/ace_master_port.sv | 172 +++++++++++++++++
 tb/tb_ace_master_port.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_master_port_pkg.sv
// Shared types and encodings for the ACE master port.
// Holds the controller FSM state enum, the snoop opcodes and the response codes.
// Used by the port and its testbench. The package contains no logic.
package ace_master_port_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        INV_AR = 3'd3,
        INV_R  = 3'd4,
        WR_AWW = 3'd5,
        WR_B   = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Snoop opcodes for the transactions this port issues
    localparam logic [3:0] ARSNOOP_READ_SHARED  = 4'b0001;
    localparam logic [3:0] ARSNOOP_CLEAN_UNIQUE = 4'b1011;
    localparam logic [2:0] AWSNOOP_WRITE_BACK   = 3'b011;

    // AXI response codes; bit 1 set means SLVERR or DECERR
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int RESP_ERR_BIT   = 1;
    localparam int RRESP_SHARED_BIT = 3;

endpackage

// File: rtl/ace_master_port_if.sv
// ACE channel bundle between the master port and the interconnect.
// Pure wiring, no latency.
// Each channel is valid/ready; rack/wack are one-cycle acknowledges from the master.
interface ace_master_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arsnoop;
    logic                  arvalid;
    logic                  arready;

    logic [LINE_WIDTH-1:0] rdata;
    logic [3:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic                  rack;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awsnoop;
    logic                  awvalid;
    logic                  awready;

    logic [LINE_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic                  wack;

    modport master (
        output araddr, arsnoop, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready, rack,
        output awaddr, awsnoop, awvalid,
        input  awready,
        output wdata, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready, wack
    );

    modport slave (
        input  araddr, arsnoop, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready, rack,
        input  awaddr, awsnoop, awvalid,
        output awready,
        input  wdata, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready, wack
    );

endinterface

// File: rtl/ace_master_port.sv
// Turns cache-controller level requests into single ACE ReadShared/CleanUnique/WriteBack transactions.
// Latency: address valid the cycle after a request is seen in IDLE; ace_ready one cycle after the final R/B handshake.
// Backpressure: valids are held until the matching ready; only one transaction is outstanding at a time.
module ace_master_port
    import ace_master_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read_req,
    input  logic                  i_write_req,
    input  logic                  i_invalid_req,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LINE_WIDTH-1:0] i_wb_data,
    output logic                  o_ace_ready,
    output logic [LINE_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_shared,
    output logic                  o_resp_err,
    ace_master_port_if.master     ace
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rd_data;
    logic                  r_rd_shared;
    logic                  r_resp_err;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_rack;
    logic                  r_wack;

    logic                  w_arvalid;
    logic [3:0]            w_arsnoop;
    logic                  w_rready;
    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_bready;
    logic                  w_ace_ready;
    logic                  w_any_req;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_unused;

    assign w_any_req = i_read_req | i_write_req | i_invalid_req;
    // Handshakes only count while the corresponding valid is still being presented
    assign w_aw_hs   = (r_state == WR_AWW) && !r_aw_done && ace.awready;
    assign w_w_hs    = (r_state == WR_AWW) && !r_w_done  && ace.wready;
    assign w_unused  = ^{ace.rresp[2], ace.rresp[0], ace.bresp[0]};

    // State register; reset drops straight back to IDLE, abandoning any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and channel controls; valids decode from state and done flags only
    always_comb begin
        w_state_nxt = r_state;
        w_arvalid   = 1'b0;
        w_arsnoop   = ARSNOOP_READ_SHARED;
        w_rready    = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_ace_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_write_req)        w_state_nxt = WR_AWW;
                else if (i_read_req)    w_state_nxt = RD_AR;
                else if (i_invalid_req) w_state_nxt = INV_AR;
            end
            RD_AR: begin
                w_arvalid = 1'b1;
                w_arsnoop = ARSNOOP_READ_SHARED;
                if (ace.arready) w_state_nxt = RD_R;
            end
            INV_AR: begin
                w_arvalid = 1'b1;
                w_arsnoop = ARSNOOP_CLEAN_UNIQUE;
                if (ace.arready) w_state_nxt = INV_R;
            end
            RD_R, INV_R: begin
                w_rready = 1'b1;
                if (ace.rvalid) w_state_nxt = DONE;
            end
            WR_AWW: begin
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = WR_B;
            end
            WR_B: begin
                w_bready = 1'b1;
                if (ace.bvalid) w_state_nxt = DONE;
            end
            DONE: begin
                w_ace_ready = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, read results, error latch, write-side done flags and ack pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
            r_rd_shared <= 1'b0;
            r_resp_err  <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rack      <= 1'b0;
            r_wack      <= 1'b0;
        end else begin
            r_rack <= ((r_state == RD_R) || (r_state == INV_R)) && ace.rvalid;
            r_wack <= (r_state == WR_B) && ace.bvalid;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_wb_data;
                        r_resp_err <= 1'b0;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                    end
                end
                RD_R: begin
                    if (ace.rvalid) begin
                        r_rd_data   <= ace.rdata;
                        r_rd_shared <= ace.rresp[RRESP_SHARED_BIT];
                        r_resp_err  <= ace.rresp[RESP_ERR_BIT];
                    end
                end
                INV_R: begin
                    if (ace.rvalid) r_resp_err <= ace.rresp[RESP_ERR_BIT];
                end
                WR_AWW: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                WR_B: begin
                    if (ace.bvalid) r_resp_err <= ace.bresp[RESP_ERR_BIT];
                end
                default: ;
            endcase
        end
    end

    assign ace.araddr   = r_addr;
    assign ace.arsnoop  = w_arsnoop;
    assign ace.arvalid  = w_arvalid;
    assign ace.rready   = w_rready;
    assign ace.rack     = r_rack;
    assign ace.awaddr   = r_addr;
    assign ace.awsnoop  = AWSNOOP_WRITE_BACK;
    assign ace.awvalid  = w_awvalid;
    assign ace.wdata    = r_wdata;
    assign ace.wvalid   = w_wvalid;
    assign ace.bready   = w_bready;
    assign ace.wack     = r_wack;

    assign o_ace_ready  = w_ace_ready;
    assign o_rd_data    = r_rd_data;
    assign o_rd_shared  = r_rd_shared;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_ace_master_port.sv
// Directed self-checking bench for ace_master_port.
// Inputs change and outputs are sampled 1ns after the rising edge.
// The bench plays the interconnect and drives ready/valid by hand.
module tb_ace_master_port;
    import ace_master_port_pkg::*;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read_req, i_write_req, i_invalid_req;
    logic [AW-1:0] i_req_addr;
    logic [LW-1:0] i_wb_data;
    logic          o_ace_ready, o_rd_shared, o_resp_err;
    logic [LW-1:0] o_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [LW-1:0] pat_a5, pat_5a, pat_ff, pat_wb1, pat_wb2;

    ace_master_port_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) ace();

    ace_master_port #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read_req   (i_read_req),
        .i_write_req  (i_write_req),
        .i_invalid_req(i_invalid_req),
        .i_req_addr   (i_req_addr),
        .i_wb_data    (i_wb_data),
        .o_ace_ready  (o_ace_ready),
        .o_rd_data    (o_rd_data),
        .o_rd_shared  (o_rd_shared),
        .o_resp_err   (o_resp_err),
        .ace          (ace)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat_a5  = {16{8'hA5}};
        pat_5a  = {16{8'h5A}};
        pat_ff  = {16{8'hFF}};
        pat_wb1 = {8{16'h1234}};
        pat_wb2 = {8{16'hCAFE}};

        rst = 1'b1;
        i_read_req = 0; i_write_req = 0; i_invalid_req = 0;
        i_req_addr = '0; i_wb_data = '0;
        ace.arready = 0; ace.rdata = '0; ace.rresp = '0; ace.rvalid = 0;
        ace.awready = 0; ace.wready = 0; ace.bresp = '0; ace.bvalid = 0;

        tick(); tick();
        chk("rst_ace_ready", o_ace_ready, 0);
        chk("rst_arvalid",   ace.arvalid, 0);
        chk("rst_awvalid",   ace.awvalid, 0);
        chk("rst_wvalid",    ace.wvalid, 0);
        chk("rst_rready",    ace.rready, 0);
        chk("rst_bready",    ace.bready, 0);
        chk("rst_rack",      ace.rack, 0);
        chk("rst_wack",      ace.wack, 0);
        chk("rst_resp_err",  o_resp_err, 0);
        chk("rst_rd_shared", o_rd_shared, 0);
        chk("rst_rd_data",   o_rd_data, 0);
        chk("rst_araddr",    ace.araddr, 0);
        rst = 1'b0;
        tick();

        // ReadShared: arready after two cycles, shared clean data
        i_read_req = 1; i_req_addr = 32'h1000;
        tick();
        chk("rd_arvalid", ace.arvalid, 1);
        chk("rd_araddr",  ace.araddr, 32'h1000);
        chk("rd_arsnoop", ace.arsnoop, 4'b0001);
        i_read_req = 0; i_req_addr = 32'hDEAD;
        tick();
        chk("rd_ar_hold",      ace.arvalid, 1);
        chk("rd_araddr_hold",  ace.araddr, 32'h1000);
        ace.arready = 1;
        tick();
        ace.arready = 0;
        chk("rd_ar_drop", ace.arvalid, 0);
        chk("rd_rready",  ace.rready, 1);
        chk("rd_no_ready_yet", o_ace_ready, 0);
        ace.rvalid = 1; ace.rdata = pat_a5; ace.rresp = 4'b1000;
        tick();
        ace.rvalid = 0; ace.rdata = '0; ace.rresp = '0;
        chk("rd_ace_ready", o_ace_ready, 1);
        chk("rd_rack",      ace.rack, 1);
        chk("rd_data",      o_rd_data, pat_a5);
        chk("rd_shared",    o_rd_shared, 1);
        chk("rd_resp_err",  o_resp_err, 0);
        chk("rd_rready_off", ace.rready, 0);
        tick();
        chk("rd_ready_pulse", o_ace_ready, 0);
        chk("rd_rack_pulse",  ace.rack, 0);
        chk("rd_data_held",   o_rd_data, pat_a5);
        chk("rd_idle_arvalid", ace.arvalid, 0);

        // write_req and read_req together: WriteBack first, then ReadShared
        i_write_req = 1; i_read_req = 1; i_req_addr = 32'h2000; i_wb_data = pat_wb1;
        tick();
        chk("wr_awvalid", ace.awvalid, 1);
        chk("wr_wvalid",  ace.wvalid, 1);
        chk("wr_awsnoop", ace.awsnoop, 3'b011);
        chk("wr_awaddr",  ace.awaddr, 32'h2000);
        chk("wr_wdata",   ace.wdata, pat_wb1);
        chk("wr_no_ar",   ace.arvalid, 0);
        ace.awready = 1; ace.wready = 1;
        tick();
        ace.awready = 0; ace.wready = 0;
        i_write_req = 0;
        chk("wr_aw_drop", ace.awvalid, 0);
        chk("wr_w_drop",  ace.wvalid, 0);
        chk("wr_bready",  ace.bready, 1);
        ace.bvalid = 1; ace.bresp = RESP_OKAY;
        tick();
        ace.bvalid = 0;
        chk("wr_ace_ready", o_ace_ready, 1);
        chk("wr_wack",      ace.wack, 1);
        chk("wr_resp_err",  o_resp_err, 0);
        i_req_addr = 32'h3000;
        tick();
        chk("wr_idle_gap_ready", o_ace_ready, 0);
        chk("wr_idle_gap_ar",    ace.arvalid, 0);
        chk("wr_wack_pulse",     ace.wack, 0);
        tick();
        chk("rd2_arvalid", ace.arvalid, 1);
        chk("rd2_arsnoop", ace.arsnoop, 4'b0001);
        chk("rd2_araddr",  ace.araddr, 32'h3000);
        i_read_req = 0;
        ace.arready = 1;
        tick();
        ace.arready = 0;
        ace.rvalid = 1; ace.rdata = pat_5a; ace.rresp = 4'b0000;
        tick();
        ace.rvalid = 0; ace.rdata = '0;
        chk("rd2_ace_ready", o_ace_ready, 1);
        chk("rd2_data",      o_rd_data, pat_5a);
        chk("rd2_shared",    o_rd_shared, 0);
        tick();

        // WriteBack: W accepted three cycles before AW, then a delayed SLVERR B
        i_write_req = 1; i_req_addr = 32'h4000; i_wb_data = pat_wb2;
        tick();
        i_write_req = 0;
        ace.wready = 1;
        tick();
        ace.wready = 0;
        chk("wr2_w_drop",  ace.wvalid, 0);
        chk("wr2_aw_hold1", ace.awvalid, 1);
        tick();
        chk("wr2_aw_hold2", ace.awvalid, 1);
        chk("wr2_no_bready", ace.bready, 0);
        tick();
        chk("wr2_aw_hold3", ace.awvalid, 1);
        chk("wr2_w_stays_low", ace.wvalid, 0);
        ace.awready = 1;
        tick();
        ace.awready = 0;
        chk("wr2_aw_drop", ace.awvalid, 0);
        chk("wr2_bready",  ace.bready, 1);
        tick();
        chk("wr2_b_wait",  ace.bready, 1);
        chk("wr2_no_wack", ace.wack, 0);
        ace.bvalid = 1; ace.bresp = RESP_SLVERR;
        tick();
        ace.bvalid = 0; ace.bresp = RESP_OKAY;
        chk("wr2_wack",      ace.wack, 1);
        chk("wr2_ace_ready", o_ace_ready, 1);
        chk("wr2_resp_err",  o_resp_err, 1);
        tick();
        chk("wr2_wack_once", ace.wack, 0);
        chk("wr2_err_held",  o_resp_err, 1);

        // CleanUnique with SLVERR; read data must not be touched
        i_invalid_req = 1; i_req_addr = 32'h5000;
        tick();
        i_invalid_req = 0;
        chk("inv_arvalid",   ace.arvalid, 1);
        chk("inv_arsnoop",   ace.arsnoop, 4'b1011);
        chk("inv_araddr",    ace.araddr, 32'h5000);
        chk("inv_err_clear", o_resp_err, 0);
        ace.arready = 1;
        tick();
        ace.arready = 0;
        ace.rvalid = 1; ace.rdata = pat_ff; ace.rresp = 4'b0010;
        tick();
        ace.rvalid = 0; ace.rdata = '0; ace.rresp = '0;
        chk("inv_ace_ready", o_ace_ready, 1);
        chk("inv_resp_err",  o_resp_err, 1);
        chk("inv_rack",      ace.rack, 1);
        chk("inv_rd_data",   o_rd_data, pat_5a);
        tick();

        // Reset asserted while waiting in RD_R
        i_read_req = 1; i_req_addr = 32'h6000;
        tick();
        i_read_req = 0;
        ace.arready = 1;
        tick();
        ace.arready = 0;
        chk("rst_mid_rready", ace.rready, 1);
        ace.rvalid = 1; ace.rdata = pat_ff; ace.rresp = 4'b1000;
        rst = 1;
        #1;
        chk("rstm_rready",    ace.rready, 0);
        chk("rstm_arvalid",   ace.arvalid, 0);
        chk("rstm_ace_ready", o_ace_ready, 0);
        chk("rstm_rack",      ace.rack, 0);
        chk("rstm_rd_data",   o_rd_data, 0);
        chk("rstm_resp_err",  o_resp_err, 0);
        chk("rstm_rd_shared", o_rd_shared, 0);
        chk("rstm_araddr",    ace.araddr, 0);
        tick();
        rst = 0;
        ace.rvalid = 0; ace.rdata = '0; ace.rresp = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_ready",  o_ace_ready, 0);
            chk("post_rst_rack",   ace.rack, 0);
            chk("post_rst_arvalid", ace.arvalid, 0);
            chk("post_rst_awvalid", ace.awvalid, 0);
        end
        chk("post_rst_rd_data", o_rd_data, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
